// File: rtl/arrayadd_pkg.sv
// Shared constants and FSM state encoding for the array-add datapath.
package arrayadd_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/result_ram.sv
// Result array: one write port, one registered read port, read-before-write.
module result_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; samples the pre-write value on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/result_writer.sv
// Result writer: stores a valid/ready stream of result words into the result
// array from index 0 upward and raises done after COUNT words.
// Optional feature: define RESULT_CHECKSUM_EN to add the running checksum port.
module result_writer #(
    parameter int unsigned DATA_W = arrayadd_pkg::DATA_W,
    parameter int unsigned ADDR_W = arrayadd_pkg::ADDR_W,
    parameter int unsigned COUNT  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] index,
    output logic              done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    import arrayadd_pkg::*;

    localparam int unsigned      CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(COUNT - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_beat;
    logic             start_run;

    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (cnt == LAST);
    assign index     = cnt[ADDR_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        start_run = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx  = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Run counter and done flag; one extra counter bit so COUNT can equal depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (start_run) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (last_beat) begin
                done <= 1'b1;
            end
        end
    end

`ifdef RESULT_CHECKSUM_EN
    // Running modular sum of accepted words.
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + in_data;
        end
    end
`endif

    // Writes are suppressed on a reset edge so an aborted run leaves no stray word.
    result_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (accept && !rst),
        .waddr   (index),
        .wdata   (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
